// File: rtl/calc_display_drv.sv
// calc_display_drv: receives the calculator display stream, double-buffers the
// digits (shadow while printing, active once committed) and time-multiplexes
// eight seven-segment digits with leading-zero blanking and an "Erro" screen.
module calc_display_drv #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter bit          SEG_ACT_LOW   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_ERROR = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_PRINT = 2'b11
  } status_e;

  localparam int unsigned CW       = $clog2(REFRESH_DIV);
  localparam logic [7:0]  OFF_MASK = SEG_ACT_LOW ? '1 : '0;

  status_e          st;
  status_e          status_q;
  logic             frame_start;
  logic             commit;
  logic [7:0][3:0]  shadow;
  logic [7:0][3:0]  shadow_d;
  logic [7:0][3:0]  active;

  logic [CW-1:0]    cnt;
  logic [2:0]       idx;
  logic             wrap;

  logic [3:0]       digit;
  logic             upper_zero;
  logic [6:0]       pat;
  logic [7:0]       an_sel;

  assign st          = status_e'(status);
  assign frame_start = (st == ST_PRINT) && (status_q != ST_PRINT);
  assign commit      = (status_q == ST_PRINT) && (st == ST_READY);
  assign wrap        = (cnt == CW'(REFRESH_DIV - 1));

  // Shadow update: clear on frame start before the write so stale digits vanish
  always_comb begin
    shadow_d = shadow;
    if (st == ST_PRINT) begin
      if (frame_start) begin
        shadow_d = '0;
      end
      if (!pos[3]) begin
        shadow_d[pos[2:0]] = data;
      end
    end
  end

  // Stream registers: status history, buffers, commit pulse and error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q   <= ST_ERROR;
      shadow     <= '0;
      active     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      status_q   <= st;
      shadow     <= shadow_d;
      frame_done <= commit;
      if (commit) begin
        active <= shadow;
        err    <= 1'b0;
      end else if (st == ST_ERROR) begin
        err <= 1'b1;
      end
    end
  end

  // Refresh divider and digit scan index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Segment pattern for the currently scanned digit (active-high gfedcba)
  always_comb begin
    digit      = active[idx];
    upper_zero = ((active >> {idx, 2'b00}) == '0);
    pat        = '0;
    an_sel     = 8'd1 << idx;
    if (err) begin
      case (idx)
        3'd0:       pat = 7'h5C;
        3'd1, 3'd2: pat = 7'h50;
        3'd3:       pat = 7'h79;
        default:    pat = '0;
      endcase
    end else begin
      case (digit)
        4'd0:    pat = 7'h3F;
        4'd1:    pat = 7'h06;
        4'd2:    pat = 7'h5B;
        4'd3:    pat = 7'h4F;
        4'd4:    pat = 7'h66;
        4'd5:    pat = 7'h6D;
        4'd6:    pat = 7'h7D;
        4'd7:    pat = 7'h07;
        4'd8:    pat = 7'h7F;
        4'd9:    pat = 7'h6F;
        default: pat = '0;
      endcase
      if (BLANK_LEADING && (idx != 3'd0) && upper_zero) begin
        pat = '0;
      end
    end
  end

  // Registered board outputs, polarity applied last
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= OFF_MASK;
      seg <= OFF_MASK;
    end else begin
      an  <= an_sel ^ OFF_MASK;
      seg <= {1'b0, pat} ^ OFF_MASK;
    end
  end

endmodule

// File: tb/tb_calc_display_drv.sv
// Directed bench for calc_display_drv with REFRESH_DIV=4, active-low outputs.
module tb_calc_display_drv;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_done;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  calc_display_drv #(
    .REFRESH_DIV  (4),
    .BLANK_LEADING(1'b1),
    .SEG_ACT_LOW  (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done),
    .err       (err)
  );

  // One printing cycle: status=11 with the given pos/data
  task automatic write_digit(input logic [3:0] p, input logic [3:0] d);
    status = 2'b11;
    pos    = p;
    data   = d;
    @(negedge clock);
  endtask

  // Leave printing with the given status and count frame_done pulses
  task automatic end_frame(input logic [1:0] s, output int pulses);
    status = s;
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (frame_done === 1'b1) pulses++;
    end
  endtask

  // Wait (bounded) for digit k to be selected and return its segments
  task automatic get_digit(input int k, output logic [7:0] s, output bit found);
    logic [7:0] tgt;
    tgt   = 8'd1 << k;
    tgt   = ~tgt;
    found = 1'b0;
    s     = 'x;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clock);
      if (an === tgt) begin
        found = 1'b1;
        s     = seg;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] s;
    bit         f;
    reset  = 1'b1;
    status = 2'b10;
    pos    = '0;
    data   = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL reset_an actual=%h required=%h", an, 8'hFF); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg actual=%h required=%h", seg, 8'hFF); end
    checks++;
    if (frame_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags actual=%b%b required=00", frame_done, err);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL first_slot_an actual=%h required=%h", an, 8'hFE); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL first_slot_seg actual=%h required=%h", seg, 8'hC0); end
    for (int k = 1; k < 8; k++) begin
      get_digit(k, s, f);
      checks++;
      if (!f || s !== 8'hFF) begin
        errors++; $display("FAIL reset_dark_digit%0d actual=%h found=%0d required=%h", k, s, f, 8'hFF);
      end
    end
  endtask

  task automatic test_frame();
    logic [3:0] vals [8] = '{4'd5, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [7:0] exp_seg [8] = '{8'h92, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] s;
    bit         f;
    int         p;
    for (int i = 0; i < 8; i++) write_digit(4'(i), vals[i]);
    end_frame(2'b10, p);
    checks++;
    if (p != 1) begin errors++; $display("FAIL frame_done_pulses actual=%0d required=1", p); end
    for (int k = 0; k < 8; k++) begin
      get_digit(k, s, f);
      checks++;
      if (!f || s !== exp_seg[k]) begin
        errors++; $display("FAIL frame_digit%0d actual=%h found=%0d required=%h", k, s, f, exp_seg[k]);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] trace [48];
    logic [7:0] nxt;
    int         run;
    int         bad;
    int         trans;
    bit         first;
    bit         wrapped;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      trace[i] = an;
    end
    bad = 0;
    for (int i = 0; i < 48; i++) if ($countones(~trace[i]) != 1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL scan_one_hot actual=%0d_bad required=0_bad", bad); end
    run = 1; first = 1'b1; wrapped = 1'b0; trans = 0;
    for (int i = 1; i < 48; i++) begin
      if (trace[i] === trace[i-1]) begin
        run++;
      end else begin
        trans++;
        nxt = {trace[i-1][6:0], trace[i-1][7]};
        checks++;
        if (trace[i] !== nxt) begin
          errors++; $display("FAIL scan_order actual=%h required=%h", trace[i], nxt);
        end
        if (trace[i-1] === 8'h7F && trace[i] === 8'hFE) wrapped = 1'b1;
        if (!first) begin
          checks++;
          if (run != 4) begin errors++; $display("FAIL scan_hold actual=%0d required=4", run); end
        end
        first = 1'b0;
        run   = 1;
      end
    end
    checks++;
    if (trans < 10) begin errors++; $display("FAIL scan_transitions actual=%0d required>=10", trans); end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL scan_wrap actual=0 required=1"); end
  endtask

  task automatic test_error();
    logic [7:0] exp_seg [8] = '{8'hA3, 8'hAF, 8'hAF, 8'h86, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] s;
    bit         f;
    int         p;
    status = 2'b00;
    @(negedge clock);
    status = 2'b10;
    repeat (2) @(negedge clock);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set actual=%b required=1", err); end
    for (int k = 0; k < 8; k++) begin
      get_digit(k, s, f);
      checks++;
      if (!f || s !== exp_seg[k]) begin
        errors++; $display("FAIL err_digit%0d actual=%h found=%0d required=%h", k, s, f, exp_seg[k]);
      end
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_hold actual=%b required=1", err); end
    write_digit(4'd0, 4'd7);
    end_frame(2'b10, p);
    checks++;
    if (p != 1) begin errors++; $display("FAIL err_commit_pulses actual=%0d required=1", p); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear actual=%b required=0", err); end
    get_digit(0, s, f);
    checks++;
    if (!f || s !== 8'hF8) begin errors++; $display("FAIL err_after_digit0 actual=%h found=%0d required=%h", s, f, 8'hF8); end
    get_digit(1, s, f);
    checks++;
    if (!f || s !== 8'hFF) begin errors++; $display("FAIL err_after_digit1 actual=%h found=%0d required=%h", s, f, 8'hFF); end
  endtask

  task automatic test_abort();
    logic [7:0] s;
    bit         f;
    int         p;
    write_digit(4'd0, 4'd3);
    write_digit(4'd1, 4'd2);
    write_digit(4'd2, 4'd1);
    end_frame(2'b10, p);
    checks++;
    if (p != 1) begin errors++; $display("FAIL abort_first_commit actual=%0d required=1", p); end
    get_digit(0, s, f);
    checks++;
    if (!f || s !== 8'hB0) begin errors++; $display("FAIL abort_123_digit0 actual=%h found=%0d required=%h", s, f, 8'hB0); end
    write_digit(4'd0, 4'd9);
    end_frame(2'b00, p);
    checks++;
    if (p != 0) begin errors++; $display("FAIL abort_no_commit actual=%0d required=0", p); end
    write_digit(4'd0, 4'd4);
    write_digit(4'd8, 4'd3);
    end_frame(2'b10, p);
    checks++;
    if (p != 1) begin errors++; $display("FAIL abort_second_commit actual=%0d required=1", p); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear actual=%b required=0", err); end
    for (int k = 0; k < 8; k++) begin
      get_digit(k, s, f);
      checks++;
      if (!f || s !== ((k == 0) ? 8'h99 : 8'hFF)) begin
        errors++; $display("FAIL abort_digit%0d actual=%h found=%0d required=%h", k, s, f, (k == 0) ? 8'h99 : 8'hFF);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    bit         f;
    int         p;
    write_digit(4'd0, 4'd5);
    status = 2'b11;
    pos    = 4'd3;
    data   = 4'd6;
    #2 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF) begin
      errors++; $display("FAIL midreset_outputs actual=%h/%h required=FF/FF", an, seg);
    end
    repeat (2) @(negedge clock);
    status = 2'b10;
    reset  = 1'b0;
    end_frame(2'b10, p);
    checks++;
    if (p != 0) begin errors++; $display("FAIL midreset_no_commit actual=%0d required=0", p); end
    for (int k = 0; k < 8; k++) begin
      get_digit(k, s, f);
      checks++;
      if (!f || s !== ((k == 0) ? 8'hC0 : 8'hFF)) begin
        errors++; $display("FAIL midreset_digit%0d actual=%h found=%0d required=%h", k, s, f, (k == 0) ? 8'hC0 : 8'hFF);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    status = 2'b10;
    pos    = '0;
    data   = '0;
    test_reset();
    test_frame();
    test_scan();
    test_error();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
